// File: rtl/piso_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piso_tx_pkg : state encoding and width helper shared by piso_tx      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package piso_tx_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bits needed to hold the values 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piso_tx_if : parallel handshake plus serial-side status of piso_tx   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface piso_tx_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] D;
  logic             s_out;
  logic             s_en;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, D,
    input  in_ready, s_out, s_en, busy, done
  );

  modport slave (
    input  in_valid, D,
    output in_ready, s_out, s_en, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/piso_tx_bitcnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piso_tx_bitcnt : loadable down-counter with a zero flag              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module piso_tx_bitcnt #(
  parameter int W = 3
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         load,
  input  wire logic         dec,
  input  wire logic [W-1:0] load_val,
  output logic              zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piso_tx : parallel-in serial-out transmitter, valid/ready input side |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic clk,
  input  wire logic reset,
  piso_tx_if.slave  bus
);

  localparam int            CW       = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] shreg_shifted;
  logic             out_bit;
  logic             cnt_zero;
  logic             cnt_dec;
  logic             shifting;
  logic             done_w;
  logic             ready_w;
  logic             xfer;
  logic             s_out_w;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
      assign out_bit       = shreg_q[WIDTH-1];
    end else begin : g_lsb_first
      assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
      assign out_bit       = shreg_q[0];
    end
  endgenerate

  piso_tx_bitcnt #(
    .W (CW)
  ) u_bitcnt (
    .clk      (clk),
    .reset    (reset),
    .load     (xfer),
    .dec      (cnt_dec),
    .load_val (CNT_LOAD),
    .zero     (cnt_zero)
  );

  // State register and shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  // A load at the done edge takes priority over the return to idle,
  // which is what makes back-to-back words gapless.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_dec = 1'b0;
    if (xfer) begin
      state_d = ST_SHIFT;
      shreg_d = bus.D;
    end else if (state_q == ST_SHIFT) begin
      if (cnt_zero) begin
        state_d = ST_IDLE;
        shreg_d = '0;
      end else begin
        shreg_d = shreg_shifted;
        cnt_dec = 1'b1;
      end
    end
  end

  always_comb begin
    shifting = (state_q == ST_SHIFT);
    done_w   = shifting && cnt_zero;
    ready_w  = !shifting || done_w;
    s_out_w  = shifting ? out_bit : 1'b0;
  end

  assign xfer = bus.in_valid && ready_w;

  assign bus.in_ready = ready_w;
  assign bus.s_out    = s_out_w;
  assign bus.s_en     = shifting;
  assign bus.busy     = shifting;
  assign bus.done     = done_w;

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_piso_tx : directed bench, piso_tx driving a shift-register SIPO   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_piso_tx;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [7:0] sipo8;
  logic [3:0] sipo4;

  piso_tx_if #(.WIDTH(8)) b8 ();
  piso_tx_if #(.WIDTH(4)) b4 ();

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8)
  );

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiving shift registers: MSB-first link fills from the bottom,
  // LSB-first link fills from the top.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sipo8 <= '0;
      sipo4 <= '0;
    end else begin
      sipo8 <= {sipo8[6:0], b8.s_out};
      sipo4 <= {b4.s_out, sipo4[3:1]};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic send8(input logic [7:0] w, input string tag);
    b8.in_valid = 1'b1;
    b8.D        = w;
    tick();
    b8.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk1({tag, "_s_en"}, b8.s_en, 1'b1);
      chk1({tag, "_s_out"}, b8.s_out, w[7-i]);
      chk1({tag, "_done"}, b8.done, (i == 7));
      tick();
    end
    chk8({tag, "_sipo"}, sipo8, w);
    chk1({tag, "_s_en_end"}, b8.s_en, 1'b0);
  endtask

  task automatic send4(input logic [3:0] w, input string tag);
    b4.in_valid = 1'b1;
    b4.D        = w;
    tick();
    b4.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1({tag, "_s_en"}, b4.s_en, 1'b1);
      chk1({tag, "_s_out"}, b4.s_out, w[i]);
      chk1({tag, "_done"}, b4.done, (i == 3));
      tick();
    end
    chk8({tag, "_sipo"}, {4'h0, sipo4}, {4'h0, w});
  endtask

  initial begin
    logic [7:0] wa;
    logic [7:0] wb;

    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    b8.in_valid = 1'b0;
    b8.D        = '0;
    b4.in_valid = 1'b0;
    b4.D        = '0;

    // Reset state
    #2;
    chk1("rst_in_ready", b8.in_ready, 1'b1);
    chk1("rst_s_en", b8.s_en, 1'b0);
    chk1("rst_s_out", b8.s_out, 1'b0);
    chk1("rst_busy", b8.busy, 1'b0);
    chk1("rst_done", b8.done, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Single word, MSB first
    send8(8'hA5, "t1");

    // Back-to-back with in_valid held high through the first word
    wa = 8'h3C;
    wb = 8'hC3;
    b8.in_valid = 1'b1;
    b8.D        = wa;
    tick();
    b8.D = wb;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        chk8("t2_sipo_first", sipo8, wa);
        b8.in_valid = 1'b0;
      end
      chk1("t2_s_en", b8.s_en, 1'b1);
      chk1("t2_s_out", b8.s_out, (i < 8) ? wa[7-i] : wb[15-i]);
      chk1("t2_done", b8.done, (i == 7) || (i == 15));
      chk1("t2_in_ready", b8.in_ready, (i == 7) || (i == 15));
      tick();
    end
    chk8("t2_sipo_second", sipo8, wb);
    chk1("t2_s_en_end", b8.s_en, 1'b0);

    // D churns while shifting; only the handshake value goes out
    wa = 8'h5A;
    b8.in_valid = 1'b1;
    b8.D        = wa;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk1("t3_s_out", b8.s_out, wa[7-i]);
      chk1("t3_in_ready", b8.in_ready, (i == 7));
      if (i == 7) b8.in_valid = 1'b0;
      b8.D = 8'(i * 29 + 7);
      tick();
    end
    chk8("t3_sipo", sipo8, wa);
    chk1("t3_idle", b8.s_en, 1'b0);

    // Asynchronous reset during the 4th bit of 8'hFF
    b8.in_valid = 1'b1;
    b8.D        = 8'hFF;
    tick();
    b8.in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk1("t4_pre_s_en", b8.s_en, 1'b1);
    chk1("t4_pre_s_out", b8.s_out, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk1("t4_s_en", b8.s_en, 1'b0);
    chk1("t4_s_out", b8.s_out, 1'b0);
    chk1("t4_busy", b8.busy, 1'b0);
    chk1("t4_done", b8.done, 1'b0);
    chk1("t4_in_ready", b8.in_ready, 1'b1);
    tick();
    chk1("t4_held_s_en", b8.s_en, 1'b0);
    chk1("t4_held_done", b8.done, 1'b0);
    reset = 1'b1;
    tick();
    chk1("t4_post_done", b8.done, 1'b0);
    send8(8'h81, "t4");

    // LSB-first 4-bit instance
    send4(4'b0001, "t5");

    // Words separated by three idle cycles
    send8(8'h6B, "t6a");
    for (int i = 0; i < 3; i++) begin
      chk1("t6_gap_s_en", b8.s_en, 1'b0);
      chk1("t6_gap_s_out", b8.s_out, 1'b0);
      tick();
    end
    send8(8'hD4, "t6b");
    send4(4'hA, "t6c");
    for (int i = 0; i < 3; i++) begin
      chk1("t6_gap4_s_en", b4.s_en, 1'b0);
      chk1("t6_gap4_s_out", b4.s_out, 1'b0);
      tick();
    end
    send4(4'h5, "t6d");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
